conv_sequencer: RTL and testbench

Control FSM for the 8-sample by 4-tap convolution datapath. It loads the x and f sample memories through two independent valid/ready input streams. It then sequences reads and the accumulator enable and clear for each output window, and presents each finished sum on a valid/ready output handshake. The datapath instantiates it beside the x memory, the f memory and the multiply-accumulate unit. Each memory has a synchronous write and a registered read with 1-cycle latency.

---
 rtl/conv_sequencer.sv | 152 +++++++++++++++
 tb/tb_conv_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Control FSM for the 8-sample x 4-tap convolution datapath: loads both sample
// memories, walks each output window through the MAC and hands the sum downstream.
module conv_sequencer #(
  parameter int N_X   = 8,
  parameter int N_F   = 4,
  parameter int LOG_X = 3,
  parameter int LOG_F = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  input  logic             s_valid_f,
  output logic             s_ready_f,
  output logic [LOG_X-1:0] x_addr,
  output logic             x_wr_en,
  output logic [LOG_F-1:0] f_addr,
  output logic             f_wr_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             conv_done
);

  localparam int XCW = $clog2(N_X + 1);
  localparam int FCW = $clog2(N_F + 1);
  localparam int BW  = LOG_X + 1;

  localparam logic [XCW-1:0] X_FULL    = XCW'(N_X);
  localparam logic [FCW-1:0] F_FULL    = FCW'(N_F);
  localparam logic [FCW-1:0] K_LAST    = FCW'(N_F - 1);
  localparam logic [BW-1:0]  BASE_LAST = BW'(N_X - N_F);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUT} state_t;

  state_t           state_q, state_d;
  logic [XCW-1:0]   x_cnt_q, x_cnt_d;
  logic [FCW-1:0]   f_cnt_q, f_cnt_d;
  logic [BW-1:0]    base_q, base_d;
  logic [FCW-1:0]   k_q, k_d;
  logic             pipe_v_q, pipe_v_d;

  logic             x_ready, f_ready, x_wr, f_wr;
  logic [LOG_X-1:0] x_a;
  logic [LOG_F-1:0] f_a;
  logic             clr, en, valid, done;

  always_comb begin
    state_d  = state_q;
    x_cnt_d  = x_cnt_q;
    f_cnt_d  = f_cnt_q;
    base_d   = base_q;
    k_d      = k_q;
    pipe_v_d = 1'b0;
    x_ready  = 1'b0;
    f_ready  = 1'b0;
    x_wr     = 1'b0;
    f_wr     = 1'b0;
    x_a      = '0;
    f_a      = '0;
    clr      = 1'b0;
    en       = pipe_v_q;
    valid    = 1'b0;
    done     = 1'b0;

    case (state_q)
      LOAD: begin
        x_ready = (x_cnt_q < X_FULL);
        f_ready = (f_cnt_q < F_FULL);
        x_wr    = s_valid_x & x_ready;
        f_wr    = s_valid_f & f_ready;
        x_a     = x_cnt_q[LOG_X-1:0];
        f_a     = f_cnt_q[LOG_F-1:0];
        if (x_wr) x_cnt_d = x_cnt_q + XCW'(1);
        if (f_wr) f_cnt_d = f_cnt_q + FCW'(1);
        // Leave as soon as the last outstanding beat lands.
        if ((x_cnt_d == X_FULL) && (f_cnt_d == F_FULL)) begin
          state_d = COMPUTE;
          base_d  = '0;
          k_d     = '0;
        end
      end
      COMPUTE: begin
        x_a      = base_q[LOG_X-1:0] + LOG_X'(k_q);
        f_a      = k_q[LOG_F-1:0];
        clr      = (k_q == '0);
        pipe_v_d = 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + FCW'(1);
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        valid = 1'b1;
        if (m_ready_y) begin
          if (base_q == BASE_LAST) begin
            done    = 1'b1;
            x_cnt_d = '0;
            f_cnt_d = '0;
            base_d  = '0;
            k_d     = '0;
            state_d = LOAD;
          end else begin
            base_d  = base_q + BW'(1);
            k_d     = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= LOAD;
      x_cnt_q  <= '0;
      f_cnt_q  <= '0;
      base_q   <= '0;
      k_q      <= '0;
      pipe_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_cnt_q  <= x_cnt_d;
      f_cnt_q  <= f_cnt_d;
      base_q   <= base_d;
      k_q      <= k_d;
      pipe_v_q <= pipe_v_d;
    end
  end

  // Every output is held low for as long as reset is asserted.
  assign s_ready_x = reset & x_ready;
  assign s_ready_f = reset & f_ready;
  assign x_wr_en   = reset & x_wr;
  assign f_wr_en   = reset & f_wr;
  assign x_addr    = reset ? x_a : '0;
  assign f_addr    = reset ? f_a : '0;
  assign acc_clr   = reset & clr;
  assign acc_en    = reset & en;
  assign m_valid_y = reset & valid;
  assign conv_done = reset & done;

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: drives frames through an attached memory/MAC model and
// compares every control cycle and every finished sum against a window-level model.
module tb_conv_sequencer;

  localparam int N_X   = 8;
  localparam int N_F   = 4;
  localparam int LOG_X = 3;
  localparam int LOG_F = 2;
  localparam int N_OUT = N_X - N_F + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid_x, s_ready_x, s_valid_f, s_ready_f;
  logic [LOG_X-1:0] x_addr;
  logic [LOG_F-1:0] f_addr;
  logic             x_wr_en, f_wr_en, acc_clr, acc_en;
  logic             m_valid_y, m_ready_y, conv_done;

  int checkCount = 0;
  int errCount   = 0;

  logic [7:0]  xFrame [N_X];
  logic [7:0]  fFrame [N_F];
  int          expY   [N_OUT];
  logic [7:0]  xData = 8'd0;
  logic [7:0]  fData = 8'd0;
  logic [7:0]  xMem   [N_X];
  logic [7:0]  fMem   [N_F];
  logic [7:0]  xRd, fRd;
  logic [31:0] acc = 32'd0;

  always #5 clk = ~clk;

  conv_sequencer #(.N_X(N_X), .N_F(N_F), .LOG_X(LOG_X), .LOG_F(LOG_F)) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .x_addr(x_addr), .x_wr_en(x_wr_en),
    .f_addr(f_addr), .f_wr_en(f_wr_en),
    .acc_clr(acc_clr), .acc_en(acc_en),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .conv_done(conv_done)
  );

  // Datapath stand-in: sync-write memories, 1-cycle registered reads, MAC.
  always @(posedge clk) begin
    if (x_wr_en) xMem[x_addr] <= xData;
    if (f_wr_en) fMem[f_addr] <= fData;
    xRd <= xMem[x_addr];
    fRd <= fMem[f_addr];
    if (acc_clr)     acc <= 32'd0;
    else if (acc_en) acc <= acc + 32'(xRd) * 32'(fRd);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0d required %0d", tag, actual, expected);
    end
  endtask

  function automatic void buildExpected();
    for (int b = 0; b < N_OUT; b++) begin
      expY[b] = 0;
      for (int k = 0; k < N_F; k++) expY[b] += int'(xFrame[b+k]) * int'(fFrame[k]);
    end
  endfunction

  function automatic logic [31:0] packOuts();
    return {19'd0, s_ready_x, s_ready_f, x_addr, x_wr_en, f_addr, f_wr_en,
            acc_clr, acc_en, m_valid_y, conv_done};
  endfunction

  // xMode: 0 every cycle, 1 every other cycle, 2 random; fFirst holds x until f is full.
  task automatic loadFrame(input int xMode, input bit fFirst);
    int xSent = 0;
    int fSent = 0;
    int xWrSeen = 0;
    bit xv, fv, expXw, expFw;
    for (int cyc = 0; cyc < 200 && (xSent < N_X || fSent < N_F); cyc++) begin
      @(negedge clk);
      if (fSent < N_F) fv = (xMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      else             fv = 1'($urandom_range(0, 1));
      if (xSent >= N_X)                 xv = 1'($urandom_range(0, 1));
      else if (fFirst && fSent < N_F)   xv = 1'b0;
      else if (xMode == 0)              xv = 1'b1;
      else if (xMode == 1)              xv = (cyc % 2 == 0);
      else                              xv = 1'($urandom_range(0, 1));
      s_valid_x = xv;
      s_valid_f = fv;
      xData = (xSent < N_X) ? xFrame[xSent] : 8'hEE;
      fData = (fSent < N_F) ? fFrame[fSent] : 8'hEE;
      #1;
      expXw = xv && (xSent < N_X);
      expFw = fv && (fSent < N_F);
      checkOutput("s_ready_x", 32'(s_ready_x), 32'(xSent < N_X));
      checkOutput("s_ready_f", 32'(s_ready_f), 32'(fSent < N_F));
      checkOutput("x_wr_en", 32'(x_wr_en), 32'(expXw));
      checkOutput("f_wr_en", 32'(f_wr_en), 32'(expFw));
      if (expXw) checkOutput("x_addr_wr", 32'(x_addr), 32'(xSent));
      if (expFw) checkOutput("f_addr_wr", 32'(f_addr), 32'(fSent));
      checkOutput("ctrl_in_load", {28'd0, acc_clr, acc_en, m_valid_y, conv_done}, 32'd0);
      xWrSeen += int'(x_wr_en);
      xSent   += int'(expXw);
      fSent   += int'(expFw);
    end
    checkOutput("load_x_writes", 32'(xWrSeen), 32'(N_X));
  endtask

  // Window model: each window is 4 issue cycles, 1 drain cycle, then OUT until accepted.
  task automatic runFrame(input int readyMode, input int stall, input int abortW);
    int off = 0;
    int w = 0;
    int stallLeft = stall;
    bit finished = 1'b0;
    bit mr, hs;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      if (w == abortW && off == 1) begin
        reset = 1'b0; s_valid_x = 1'b1; s_valid_f = 1'b1; m_ready_y = 1'b1;
        #1;
        checkOutput("outs_in_reset", packOuts(), 32'd0);
        @(negedge clk);
        reset = 1'b1; s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
        #1;
        checkOutput("ready_after_reset", {30'd0, s_ready_x, s_ready_f}, 32'd3);
        checkOutput("no_out_after_abort", {30'd0, m_valid_y, conv_done}, 32'd0);
        finished = 1'b1;
      end else begin
        if (off >= 5 && stallLeft > 0) begin
          mr = 1'b0;
          stallLeft--;
        end else begin
          mr = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        m_ready_y = mr;
        if (cyc == 0) {s_valid_x, s_valid_f} = 2'b11;
        else          {s_valid_x, s_valid_f} = 2'($urandom_range(0, 3));
        #1;
        checkOutput("in_gated", {28'd0, s_ready_x, s_ready_f, x_wr_en, f_wr_en}, 32'd0);
        checkOutput("acc_clr", 32'(acc_clr), 32'(off == 0));
        checkOutput("acc_en", 32'(acc_en), 32'(off >= 1 && off <= 4));
        checkOutput("m_valid_y", 32'(m_valid_y), 32'(off >= 5));
        if (off <= 3) begin
          checkOutput("x_addr_rd", 32'(x_addr), 32'(w + off));
          checkOutput("f_addr_rd", 32'(f_addr), 32'(off));
        end
        hs = (off >= 5) && mr;
        checkOutput("conv_done", 32'(conv_done), 32'(hs && w == N_OUT - 1));
        if (hs) begin
          checkOutput($sformatf("y%0d", w), acc, 32'(expY[w]));
          if (w == N_OUT - 1) finished = 1'b1;
          else begin
            w++;
            off = 0;
          end
        end else begin
          off++;
        end
      end
    end
    if (!finished) checkOutput("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input int xMode, input bit fFirst, input int readyMode,
                               input int stall, input int abortW);
    buildExpected();
    loadFrame(xMode, fFirst);
    runFrame(readyMode, stall, abortW);
    if (abortW < 0) begin
      @(negedge clk);
      s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
      #1;
      checkOutput("back_to_load", {30'd0, s_ready_x, s_ready_f}, 32'd3);
    end
  endtask

  task automatic randomFrame();
    for (int i = 0; i < N_X; i++) xFrame[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N_F; i++) fFrame[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    reset = 1'b0;
    s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
    repeat (2) @(negedge clk);
    s_valid_x = 1'b1; s_valid_f = 1'b1; m_ready_y = 1'b1;
    #1;
    checkOutput("reset_outs", packOuts(), 32'd0);
    @(negedge clk);
    reset = 1'b1; s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
    #1;
    checkOutput("reset_ready", {30'd0, s_ready_x, s_ready_f}, 32'd3);

    $display("[TB] frame x=1..8 f=1,1,1,1 simultaneous load");
    for (int i = 0; i < N_X; i++) xFrame[i] = 8'(i + 1);
    for (int i = 0; i < N_F; i++) fFrame[i] = 8'd1;
    applyStimulus(0, 1'b0, 0, 0, -1);

    $display("[TB] frame x=8..1 f=1..4, f first, toggling x, output stall");
    for (int i = 0; i < N_X; i++) xFrame[i] = 8'(N_X - i);
    for (int i = 0; i < N_F; i++) fFrame[i] = 8'(i + 1);
    applyStimulus(1, 1'b1, 0, 10, -1);

    $display("[TB] random frame aborted by reset in window 3, then fresh frame");
    randomFrame();
    applyStimulus(2, 1'b0, 1, 0, 2);
    randomFrame();
    applyStimulus(2, 1'b0, 1, 0, -1);

    for (int r = 0; r < 4; r++) begin
      randomFrame();
      applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1, $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule
